multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB and generates the per-cycle datapath enables.
- Its PCWre output drives the PC register's write enable. pc_src selects the next-PC mux that feeds newAddress.
- Also keeps a retired-instruction counter for the testbench and debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from ID onward (IR latched at end of IF).
- zero  in  1  ALU zero flag; sampled in EXE.
- PCWre  out  1  PC write enable; 1 for exactly one cycle per retired instruction.
- IRWre  out  1  instruction register write enable.
- RegWre  out  1  register file write enable.
- mem_rd  out  1  data memory read.
- mem_wr  out  1  data memory write.
- alu_src_b  out  1  0 = rt data, 1 = sign-extended immediate.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = writeback from memory data.
- alu_op  out  3  000 add, 001 sub, 010 R-type (funct decoded by ALU control).
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target.
- state  out  3  current state encoding.
- halted  out  1  1 while in HALT.
- instr_count  out  CNT_W  number of PCWre pulses since reset.

Behaviour:
- Reset is synchronous and active-high on one clock. At a rising CLK edge with Reset=1:
  - state <= IF, instr_count <= 0.
  - Reset overrides every transition, including from HALT and from mid-instruction.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- State is registered. All outputs are combinational from (state, opcode, zero). Outputs not listed for a state are 0.
- While Reset is held, state=IF, so the outputs show IF values: IRWre=1, everything else 0.
- Opcodes decoded:
  - R-type = 000000, addi = 001000, lw = 100011, sw = 101011, beq = 000100, j = 000010, halt = 111111.
  - Any other opcode is a NOP.
- IF:
  - IRWre=1.
  - Next state: ID.
- ID:
  - j: PCWre=1, pc_src=10; next state IF.
  - halt: next state HALT; PCWre=0.
  - NOP: PCWre=1, pc_src=00; next state IF.
  - Others: next state EXE.
- EXE:
  - R-type: alu_op=010, alu_src_b=0; next state WB.
  - addi / lw / sw: alu_op=000, alu_src_b=1. addi goes to WB; lw and sw go to MEM.
  - beq: alu_op=001, alu_src_b=0, PCWre=1, pc_src = zero ? 01 : 00; next state IF.
- MEM:
  - Hold alu_src_b=1 and alu_op=000.
  - lw: mem_rd=1; next state WB.
  - sw: mem_wr=1, PCWre=1, pc_src=00; next state IF.
- WB:
  - RegWre=1, PCWre=1, pc_src=00; next state IF.
  - R-type: reg_dst=1, alu_op=010.
  - addi: reg_dst=0, alu_src_b=1.
  - lw: reg_dst=0, mem_to_reg=1.
- HALT:
  - All enables 0, halted=1.
  - State stays HALT until Reset.
- Defensive: an unused state encoding (110, 111) has next state IF, with all outputs 0.
- Cycle counts per instruction:
  - j / NOP: 2 cycles.
  - beq: 3 cycles.
  - R-type / addi / sw: 4 cycles.
  - lw: 5 cycles.
- Exactly one PCWre pulse per instruction, on its last cycle.
- instr_count:
  - Increments by 1 at each rising edge where PCWre=1 and Reset=0.
  - Wraps modulo 2^CNT_W without saturation.
  - Reset has priority over the increment.
- zero is ignored outside EXE. opcode is ignored in IF and HALT.

Test Plan:
- Reset then R-type (opcode 000000) repeated:
  - States are IF, ID, EXE, WB, IF, with PCWre high only in WB.
  - RegWre=1 and reg_dst=1 in WB.
  - instr_count = 2 after 8 cycles.
- lw (100011):
  - States are IF, ID, EXE, MEM, WB.
  - mem_rd=1 only in MEM; mem_to_reg=1 and RegWre=1 in WB.
  - 5 cycles per instruction. sw ends in MEM with mem_wr=1 and PCWre=1.
- beq (000100):
  - With zero=1 in EXE: pc_src=01 and PCWre=1.
  - Repeat with zero=0: pc_src=00.
  - zero toggled during ID has no effect.
- j (000010): PCWre=1 and pc_src=10 in ID, next state IF. An undefined opcode 010101 behaves as a 2-cycle NOP with pc_src=00.
- halt (111111):
  - Enters HALT and stays there for 20 cycles with PCWre=0, halted=1, and instr_count frozen.
  - Reset=1 for one edge gives state IF and instr_count 0.
- Reset mid-instruction:
  - Reset asserted in MEM of a lw gives state IF next cycle, with no RegWre pulse and the counter cleared.
  - Forcing instr_count near 2^CNT_W-1 (CNT_W=4) wraps it 15 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB control FSM for the MIPS-subset CPU, with a retired-instruction counter.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_src_b,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_nop;
    assign is_r    = opcode == 6'b000000;
    assign is_addi = opcode == 6'b001000;
    assign is_lw   = opcode == 6'b100011;
    assign is_sw   = opcode == 6'b101011;
    assign is_beq  = opcode == 6'b000100;
    assign is_j    = opcode == 6'b000010;
    assign is_halt = opcode == 6'b111111;
    assign is_nop  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_j || is_halt);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, PCWre};
        end
    end

    always_comb begin
        state_d    = S_IF;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        RegWre     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_src_b  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 3'b000;
        pc_src     = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                // j, halt and NOP finish here; everything else needs the ALU
                PCWre   = is_j || is_nop;
                pc_src  = is_j ? 2'b10 : 2'b00;
                state_d = (is_j || is_nop) ? S_IF : is_halt ? S_HALT : S_EXE;
            end
            S_EXE: begin
                alu_op    = is_beq ? 3'b001 : is_r ? 3'b010 : 3'b000;
                alu_src_b = !(is_beq || is_r);
                PCWre     = is_beq;
                pc_src    = (is_beq && zero) ? 2'b01 : 2'b00;
                state_d   = is_beq ? S_IF : (is_r || is_addi) ? S_WB : S_MEM;
            end
            S_MEM: begin
                alu_src_b = 1'b1;
                mem_rd    = is_lw;
                mem_wr    = is_sw;
                PCWre     = is_sw;
                state_d   = is_sw ? S_IF : S_WB;
            end
            S_WB: begin
                RegWre     = 1'b1;
                PCWre      = 1'b1;
                reg_dst    = is_r;
                alu_op     = is_r ? 3'b010 : 3'b000;
                alu_src_b  = is_addi;
                mem_to_reg = is_lw;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IF;
        endcase
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule
